// File: rtl/noc_serial_receiver_pkg.sv
// Shared NoC receive-side types and helpers: flit format, address type, FSM states, n_flits().
// The flit payload width is taken from `FLIT_DATA_WIDTH (8 if not defined elsewhere).
`ifndef FLIT_DATA_WIDTH
`define FLIT_DATA_WIDTH 8
`endif

package noc_serial_receiver_pkg;

    localparam int FLIT_W = `FLIT_DATA_WIDTH;

    typedef enum logic [1:0] {
        HEADER = 2'd0,
        DATA   = 2'd1,
        TAIL   = 2'd2
    } flit_type_e;

    typedef struct packed {
        flit_type_e        flit_type;
        logic [FLIT_W-1:0] payload;
    } flit_t;

    typedef logic [7:0] addr_t;

    typedef enum logic [1:0] {
        IDLE,
        RECEIVING,
        FULL
    } rx_state_e;

    // Number of flits needed to carry a payload of the given width; shared with the sender.
    function automatic int n_flits(input int bits);
        return (bits + FLIT_W - 1) / FLIT_W;
    endfunction

endpackage

// File: rtl/node_port.sv
// Serial NoC link between a router port and an endpoint: enable/flit forward, ack/rej back.
interface node_port;
    import noc_serial_receiver_pkg::*;

    logic  enable;
    flit_t flit;
    logic  ack;
    logic  rej;

    modport down (input enable, input flit, output ack, output rej);
    modport up   (output enable, output flit, input ack, input rej);
endinterface

// File: rtl/noc_flit_assembler.sv
// Reassembly buffer with a saturating slot counter; flit k lands in bits [k*FLIT_W +: FLIT_W].
module noc_flit_assembler
    import noc_serial_receiver_pkg::*;
#(
    parameter int PACKET_BITS = 16,
    parameter int N_FLITS     = 2,
    parameter int CNT_W       = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic                   wr_en,
    input  logic                   last,
    input  logic [FLIT_W-1:0]      wr_data,
    output logic [PACKET_BITS-1:0] buffer,
    output logic [CNT_W-1:0]       cnt,
    output logic                   overrun
);

    localparam logic [CNT_W-1:0] N_CNT = CNT_W'(N_FLITS);

    assign overrun = (cnt >= N_CNT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            buffer <= '0;
        end else if (clear) begin
            cnt    <= '0;
            buffer <= '0;
        end else begin
            // Bits of the final flit beyond PACKET_BITS have no home and are simply not stored.
            if (wr_en) begin
                for (int i = 0; i < PACKET_BITS; i++) begin
                    if ((i / FLIT_W) == int'(cnt))
                        buffer[i] <= wr_data[i % FLIT_W];
                end
            end
            if (last)
                cnt <= '0;
            else if (wr_en)
                cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/noc_serial_receiver.sv
// NoC endpoint receiver: accepts header, reassembles DATA/TAIL flits, holds the packet until flush.
// Optional length checking (len_err port) is enabled by defining NOC_SERIAL_RX_LEN_CHECK_EN.
module noc_serial_receiver
    import noc_serial_receiver_pkg::*;
#(
    parameter int PACKET_BITS  = 16,
    parameter int PADDING_BITS = 0
) (
    input  logic                                        clk,
    input  logic                                        rst,
    node_port.down                                      down,
    input  logic                                        flush,
    output logic                                        valid,
    output logic [PACKET_BITS-1:0]                      packet,
    output logic [((PADDING_BITS > 0) ? PADDING_BITS : 1)-1:0] padding
`ifdef NOC_SERIAL_RX_LEN_CHECK_EN
    ,
    output logic                                        len_err
`endif
);

    localparam int N_FLITS = n_flits(PACKET_BITS);
    localparam int CNT_W   = $clog2(N_FLITS) + 1;

    rx_state_e        state_q, state_d;
    logic             ack_c, rej_c;
    logic             hdr_acc, wr_acc, tail_acc;
    logic [CNT_W-1:0] cnt;
    logic             overrun;

    always_comb begin
        state_d  = state_q;
        ack_c    = 1'b0;
        rej_c    = 1'b0;
        hdr_acc  = 1'b0;
        wr_acc   = 1'b0;
        tail_acc = 1'b0;
        case (state_q)
            IDLE: begin
                if (down.enable && down.flit.flit_type == HEADER) begin
                    ack_c   = 1'b1;
                    hdr_acc = 1'b1;
                    state_d = RECEIVING;
                end
            end
            RECEIVING: begin
                // A stray HEADER here is a protocol error and is dropped silently.
                ack_c = 1'b1;
                if (down.enable && down.flit.flit_type == DATA) begin
                    wr_acc = 1'b1;
                end else if (down.enable && down.flit.flit_type == TAIL) begin
                    wr_acc   = 1'b1;
                    tail_acc = 1'b1;
                    state_d  = FULL;
                end
            end
            FULL: begin
                // ack and rej both low: a waiting sender stalls instead of being refused.
                if (flush)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign down.ack = ack_c;
    assign down.rej = rej_c;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            valid   <= 1'b0;
        end else begin
            state_q <= state_d;
            valid   <= (state_d == FULL);
        end
    end

    noc_flit_assembler #(
        .PACKET_BITS(PACKET_BITS),
        .N_FLITS    (N_FLITS),
        .CNT_W      (CNT_W)
    ) u_assembler (
        .clk    (clk),
        .rst    (rst),
        .clear  (hdr_acc),
        .wr_en  (wr_acc && !overrun),
        .last   (tail_acc),
        .wr_data(down.flit.payload),
        .buffer (packet),
        .cnt    (cnt),
        .overrun(overrun)
    );

    generate
        if (PADDING_BITS > 0) begin : g_pad
            logic [PADDING_BITS-1:0] pad_q;
            always_ff @(posedge clk or posedge rst) begin
                if (rst)
                    pad_q <= '0;
                else if (hdr_acc)
                    pad_q <= down.flit.payload[PADDING_BITS-1:0];
            end
            assign padding = pad_q;
        end else begin : g_no_pad
            assign padding = 1'b0;
        end
    endgenerate

`ifdef NOC_SERIAL_RX_LEN_CHECK_EN
    localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(N_FLITS - 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            len_err <= 1'b0;
        else if (hdr_acc || (state_q == FULL && flush))
            len_err <= 1'b0;
        else if ((tail_acc && cnt != LAST_SLOT) || (wr_acc && !tail_acc && cnt >= LAST_SLOT))
            len_err <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_noc_serial_receiver.sv
// Directed bench for noc_serial_receiver: 16-bit/4-bit-padding instance plus a 12-bit instance.
module tb_noc_serial_receiver;
    import noc_serial_receiver_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush_a = 1'b0;
    logic        flush_b = 1'b0;
    logic        valid_a, valid_b;
    logic [15:0] packet_a;
    logic [11:0] packet_b;
    logic [3:0]  padding_a;
    logic        padding_b;
`ifdef NOC_SERIAL_RX_LEN_CHECK_EN
    logic        len_err_a, len_err_b;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    node_port pa();
    node_port pb();

    always #5 clk = ~clk;

    noc_serial_receiver #(.PACKET_BITS(16), .PADDING_BITS(4)) dut (
        .clk    (clk),
        .rst    (rst),
        .down   (pa),
        .flush  (flush_a),
        .valid  (valid_a),
        .packet (packet_a),
        .padding(padding_a)
`ifdef NOC_SERIAL_RX_LEN_CHECK_EN
        ,
        .len_err(len_err_a)
`endif
    );

    noc_serial_receiver #(.PACKET_BITS(12), .PADDING_BITS(0)) dut12 (
        .clk    (clk),
        .rst    (rst),
        .down   (pb),
        .flush  (flush_b),
        .valid  (valid_b),
        .packet (packet_b),
        .padding(padding_b)
`ifdef NOC_SERIAL_RX_LEN_CHECK_EN
        ,
        .len_err(len_err_b)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive one cycle on DUT A at the falling edge; outputs are sampled 1 time unit later.
    task automatic step(input logic en, input flit_type_e t, input logic [7:0] pl, input logic fl);
        @(negedge clk);
        pa.enable         = en;
        pa.flit.flit_type = t;
        pa.flit.payload   = pl;
        flush_a           = fl;
        #1;
    endtask

    task automatic step_b(input logic en, input flit_type_e t, input logic [7:0] pl);
        @(negedge clk);
        pb.enable         = en;
        pb.flit.flit_type = t;
        pb.flit.payload   = pl;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    initial begin
        pa.enable = 1'b0; pa.flit = '0;
        pb.enable = 1'b0; pb.flit = '0;
        #1;
        check("rst_ack",     pa.ack,    1'b0);
        check("rst_rej",     pa.rej,    1'b0);
        check("rst_valid",   valid_a,   1'b0);
        check("rst_packet",  packet_a,  16'h0);
        check("rst_padding", padding_a, 4'h0);
        @(negedge clk);
        rst = 1'b0;

        // Non-header in IDLE is ignored
        step(1, DATA, 8'h55, 0);  check("idle_data_ack", pa.ack, 1'b0);
        step(0, DATA, 8'h00, 0);  check("idle_data_valid", valid_a, 1'b0);

        // 1: basic transfer
        step(1, HEADER, 8'h09, 0); check("t1_hdr_ack", pa.ack, 1'b1);
        step(1, DATA,   8'hA5, 0); check("t1_data_ack", pa.ack, 1'b1);
        step(1, TAIL,   8'h3C, 0); check("t1_tail_valid_low", valid_a, 1'b0);
        step(0, DATA,   8'h00, 0);
        check("t1_valid",   valid_a,   1'b1);
        check("t1_packet",  packet_a,  16'h3CA5);
        check("t1_padding", padding_a, 4'h9);
        check("t1_full_ack", pa.ack,   1'b0);
`ifdef NOC_SERIAL_RX_LEN_CHECK_EN
        check("t1_len_err", len_err_a, 1'b0);
`endif
        step(0, DATA, 8'h00, 1); check("t1_valid_hold", valid_a, 1'b1);
        step(0, DATA, 8'h00, 0); check("t1_valid_drop", valid_a, 1'b0);

        // 2: bubble between DATA and TAIL
        step(1, HEADER, 8'h09, 0); check("t2_hdr_ack", pa.ack, 1'b1);
        step(1, DATA,   8'hA5, 0);
        step(0, TAIL,   8'hFF, 0); check("t2_bubble_ack", pa.ack, 1'b1);
        step(1, TAIL,   8'h3C, 0); check("t2_bubble_no_valid", valid_a, 1'b0);
        step(0, DATA,   8'h00, 0);
        check("t2_valid",   valid_a,   1'b1);
        check("t2_packet",  packet_a,  16'h3CA5);
        check("t2_padding", padding_a, 4'h9);

        // 3: second header stalls while FULL
        for (int i = 0; i < 5; i++) begin
            step(1, HEADER, 8'h05, 0);
            check("t3_stall_ack", pa.ack, 1'b0);
            check("t3_stall_rej", pa.rej, 1'b0);
        end
        step(1, HEADER, 8'h05, 1); check("t3_flush_cycle_ack", pa.ack, 1'b0);
        step(1, HEADER, 8'h05, 0);
        check("t3_after_flush_ack",   pa.ack,  1'b1);
        check("t3_after_flush_valid", valid_a, 1'b0);
        step(1, DATA, 8'h34, 0);
        step(1, TAIL, 8'h12, 0);
        step(0, DATA, 8'h00, 0);
        check("t3_valid",   valid_a,   1'b1);
        check("t3_packet",  packet_a,  16'h1234);
        check("t3_padding", padding_a, 4'h5);
        step(0, DATA, 8'h00, 1);
        step(0, DATA, 8'h00, 0);

        // 4: 12-bit packet on the second instance
        step_b(1, HEADER, 8'h00); check("t4_hdr_ack", pb.ack, 1'b1);
        step_b(1, DATA,   8'hFF);
        step_b(1, TAIL,   8'hFF);
        step_b(0, DATA,   8'h00);
        check("t4_valid",  valid_b,  1'b1);
        check("t4_packet", packet_b, 12'hFFF);

        // 5: reset mid-packet
        step(1, HEADER, 8'h03, 0);
        step(1, DATA,   8'h77, 0);
        step(0, DATA,   8'h00, 0); check("t5_recv_ack", pa.ack, 1'b1);
        rst = 1'b1;
        #1;
        check("t5_rst_ack",    pa.ack,   1'b0);
        check("t5_rst_valid",  valid_a,  1'b0);
        check("t5_rst_packet", packet_a, 16'h0);
        @(negedge clk);
        rst = 1'b0;
        step(1, HEADER, 8'h0A, 0); check("t5_hdr_ack", pa.ack, 1'b1);
        step(1, DATA,   8'hEF, 0);
        step(1, TAIL,   8'hBE, 0);
        step(0, DATA,   8'h00, 0);
        check("t5_valid",   valid_a,   1'b1);
        check("t5_packet",  packet_a,  16'hBEEF);
        check("t5_padding", padding_a, 4'hA);
        step(0, DATA, 8'h00, 1);
        step(0, DATA, 8'h00, 0);

        // Too many DATA flits: writes beyond the last slot are dropped
        step(1, HEADER, 8'h01, 0);
        step(1, DATA,   8'h11, 0);
        step(1, DATA,   8'h22, 0);
        step(1, DATA,   8'h33, 0);
        step(1, TAIL,   8'h44, 0);
        step(0, DATA,   8'h00, 0);
        check("ovr_valid",  valid_a,  1'b1);
        check("ovr_packet", packet_a, 16'h2211);
`ifdef NOC_SERIAL_RX_LEN_CHECK_EN
        check("ovr_len_err", len_err_a, 1'b1);
`endif
        step(0, DATA, 8'h00, 1);
        step(0, DATA, 8'h00, 0);

`ifdef NOC_SERIAL_RX_LEN_CHECK_EN
        // 6: short packet flagged, then a correct packet clears the flag
        step(1, HEADER, 8'h02, 0);
        step(1, TAIL,   8'h11, 0);
        step(0, DATA,   8'h00, 0);
        check("t6_valid",   valid_a,   1'b1);
        check("t6_len_err", len_err_a, 1'b1);
        check("t6_packet",  packet_a,  16'h0011);
        step(0, DATA, 8'h00, 1);
        step(0, DATA, 8'h00, 0);
        check("t6_flush_len_err", len_err_a, 1'b0);
        step(1, HEADER, 8'h02, 0);
        step(1, DATA,   8'h56, 0);
        step(1, TAIL,   8'h78, 0);
        step(0, DATA,   8'h00, 0);
        check("t6_ok_packet",  packet_a,  16'h7856);
        check("t6_ok_len_err", len_err_a, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
